// File: rtl/rip_lsu.sv
// Load/store unit: maps byte/half/word/dword requests onto a word-wide memory port.
// Define RIP_LSU_MISALIGNED_EN to split word-crossing accesses into two beats.
module rip_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    mem_re,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);
  localparam int unsigned NUM_COL = DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(NUM_COL);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;
  state_e state_q, state_d;

  logic                  we_q, signed_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept, req_illegal;
  int unsigned           req_bytes_i, off_i, bytes_i, end_i;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] lo_word, shifted, load_data;
  logic                  sign_bit;

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign word_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    req_bytes_i = 32'd1 << req_size;
    req_illegal = (req_size == 2'd3) && (DATA_WIDTH == 32);
`ifndef RIP_LSU_MISALIGNED_EN
    // Without splitting, anything not naturally aligned cannot be served.
    if ((32'(req_addr[OFF_W-1:0]) & (req_bytes_i - 32'd1)) != 32'd0) req_illegal = 1'b1;
`endif
    off_i   = 32'(addr_q[OFF_W-1:0]);
    bytes_i = 32'd1 << size_q;
    end_i   = off_i + bytes_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_illegal;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

`ifdef RIP_LSU_MISALIGNED_EN
  logic                  cross;
  logic [DATA_WIDTH-1:0] lo_q;

  assign cross = end_i > NUM_COL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
    end else if (state_q == StBeat1 && !we_q) begin
      lo_q <= mem_dout;
    end
  end

  assign lo_word = cross ? lo_q : mem_dout;
`else
  assign lo_word = mem_dout;
`endif

  // Low word holds the first beat; shifting the pair right by the offset aligns byte 0.
  always_comb begin
    shifted = DATA_WIDTH'({mem_dout, lo_word} >> (8 * off_i));
    unique case (size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_WIDTH-1];
    endcase
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      load_data[i] = (i < 8 * bytes_i) ? shifted[i] : (signed_q & sign_bit);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_re     = 1'b0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_din    = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = req_illegal ? StDone : StBeat0;
      end
      StBeat0: begin
        mem_addr = word_addr;
        mem_re   = !we_q;
        mem_din  = wdata_q << (8 * off_i);
        for (int unsigned i = 0; i < NUM_COL; i++) begin
          mem_we[i] = we_q && (i >= off_i) && (i < end_i);
        end
`ifdef RIP_LSU_MISALIGNED_EN
        state_d = cross ? StBeat1 : StDone;
`else
        state_d = StDone;
`endif
      end
      StBeat1: begin
`ifdef RIP_LSU_MISALIGNED_EN
        mem_addr = word_addr + ADDR_WIDTH'(NUM_COL);
        mem_re   = !we_q;
        mem_din  = wdata_q >> (8 * (NUM_COL - off_i));
        for (int unsigned i = 0; i < NUM_COL; i++) begin
          mem_we[i] = we_q && (i + NUM_COL < end_i);
        end
`endif
        state_d = StDone;
      end
      StDone: begin
        state_d    = StIdle;
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = load_data;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/rip_lsu.md
RIP_LSU -- requirements
Module: rip_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL derive NUM_COL = DATA_WIDTH/8 internally; it is not overridable.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: request handshake; transfer when both high.
REQ-007 SHALL have request fields: req_we in 1 (1=store), req_size in 2 (0 byte, 1 half, 2 word, 3 dword), req_signed in 1, req_addr in ADDR_WIDTH, req_wdata in DATA_WIDTH.
REQ-008 SHALL have response ports: resp_valid out 1, resp_err out 1, resp_rdata out DATA_WIDTH; no backpressure.
REQ-009 SHALL have memory ports: mem_re out 1, mem_we out NUM_COL, mem_addr out ADDR_WIDTH (word-aligned), mem_din out DATA_WIDTH, mem_dout in DATA_WIDTH; mem_dout is valid one cycle after mem_re.

Function
REQ-010 SHALL use FSM states IDLE, BEAT0, BEAT1, DONE; req_ready = (state==IDLE) and not rst.
REQ-011 SHALL, on accept in cycle T, latch the request; off = addr mod NUM_COL, bytes = 2^size, cross = (off+bytes > NUM_COL).
REQ-012 SHALL flag illegal when size==3 and DATA_WIDTH==32; illegal requests go IDLE->DONE at T+1 with resp_err=1 and no memory strobe.
REQ-013 SHALL in BEAT0 drive mem_addr = addr with low log2(NUM_COL) bits cleared, mem_re = !we, mem_we[i] = we and (off <= i < off+bytes).
REQ-014 SHALL in BEAT0 drive mem_din = wdata << (8*off), truncated to DATA_WIDTH.
REQ-015 SHALL go BEAT0->BEAT1 if cross, else BEAT0->DONE.
REQ-016 SHALL in BEAT1 drive mem_addr = word address + NUM_COL modulo 2^ADDR_WIDTH (wraps to 0), mem_we[i] = we and (i < off+bytes-NUM_COL), mem_din = wdata >> (8*(NUM_COL-off)); on a load, capture mem_dout into lo buffer.
REQ-017 SHALL go BEAT1->DONE and DONE->IDLE unconditionally.
REQ-018 SHALL in DONE assert resp_valid for exactly one cycle; for a load, resp_rdata = low bytes of ({hi,lo} >> 8*off), where hi = mem_dout and lo = buffer if cross else lo = mem_dout; sign-extend if req_signed else zero-extend.
REQ-019 SHALL drive resp_rdata = 0 for stores and errors, and mem_re=0, mem_we=0 in IDLE and DONE.
REQ-020 SHALL have latency: aligned access resp at T+2, crossing access at T+3, error at T+1; one request in flight; req_valid while not ready is ignored.

Reset
REQ-021 SHALL on rst force state IDLE immediately (asynchronously): mem_re=0, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, lo buffer=0, req_ready=0 while rst high.
REQ-022 SHALL abandon any in-flight request on reset; after release, no pending beat or response is emitted.

Configuration
REQ-023 SHALL honour macro RIP_LSU_MISALIGNED_EN: when defined, crossing accesses are split per REQ-015..018.
REQ-024 SHALL, when RIP_LSU_MISALIGNED_EN is undefined, treat any misaligned request (addr mod bytes != 0) as illegal per REQ-012; BEAT1 and lo buffer are not built.

Verification (DATA_WIDTH=32; mem[0x100]=0x88776655, mem[0x104]=0x44332211)
REQ-025 SHALL cover: LW 0x100 -> mem_re at T+1 addr 0x100; resp at T+2 rdata 0x88776655, err 0.
REQ-026 SHALL cover (macro on): LW 0x102 -> beats at 0x100, 0x104; resp at T+3 rdata 0x22118877; LB signed 0x103 -> 0xFFFFFF88; LHU 0x103 -> 0x00001188.
REQ-027 SHALL cover (macro on): SH wdata 0x0000ABCD at 0x107 -> T+1 addr 0x104 we 4'b1000 din 0xCD000000; T+2 addr 0x108 we 4'b0001 din 0x000000AB; resp T+3.
REQ-028 SHALL cover (macro off): LW 0x102 -> no mem_re, resp at T+1 err 1 rdata 0; SD (size 3) at 0x100 -> err 1.
REQ-029 SHALL cover: wrap, LW 0xFFFFFFFE (macro on) -> second beat addr 0x00000000.
REQ-030 SHALL cover: rst asserted during BEAT1 of a split store -> mem_we=0 same cycle, no resp_valid after release, next request served normally.
